// File: rtl/thread_pc_scheduler_pkg.sv
// thread_pc_scheduler_pkg: shared sizing, types and helpers for the fetch scheduler.
//   NUM_THREADS  hardware threads owned by the scheduler
//   TID_W        thread id width, max(1, clog2(NUM_THREADS))
//   PC_W         PC width in bits (byte address)
//   PC_INC       sequential PC increment per issue
//   RESET_PC     PC of every thread after reset
package thread_pc_scheduler_pkg;
   localparam int NUM_THREADS = 4;
   localparam int TID_W       = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
   localparam int PC_W        = 9;
   localparam int PC_INC      = 4;
   localparam int RESET_PC    = 0;

   typedef logic [TID_W-1:0] tid_t;
   typedef logic [PC_W-1:0]  pc_t;

   // Next thread id in rotation, wrapping at NUM_THREADS (which need not be a power of two).
   function automatic tid_t next_tid(tid_t t);
      return (int'(t) == NUM_THREADS - 1) ? '0 : t + tid_t'(1);
   endfunction
endpackage

// File: rtl/thread_pc_scheduler_rr_pick.sv
// rr_pick: rotating-priority picker.
//   req      request mask, bit i = requester i
//   start    index with highest priority; priority falls off upward with wrap
//   gnt_idx  first requesting index at or after start
//   gnt_vld  at least one request present
module rr_pick
   import thread_pc_scheduler_pkg::*;
#(
   parameter int N = NUM_THREADS,
   parameter int W = TID_W
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic [W-1:0] gnt_idx,
   output logic         gnt_vld
);
   localparam int W1 = W + 1;

   logic [W:0]   sum;
   logic [W-1:0] idx;

   // Scan from the farthest offset back to the nearest so the nearest requester wins.
   always_comb begin
      gnt_idx = '0;
      gnt_vld = 1'b0;
      sum     = '0;
      idx     = '0;
      for (int i = N - 1; i >= 0; i--) begin
         sum = {1'b0, start} + W1'(i);
         idx = (sum >= W1'(N)) ? W'(sum - W1'(N)) : W'(sum);
         if (req[idx]) begin
            gnt_idx = idx;
            gnt_vld = 1'b1;
         end
      end
   end
endmodule

// File: rtl/thread_pc_scheduler.sv
// thread_pc_scheduler: per-thread PC owner and IF-stage fetch selector.
//   clk, sys_rstb               clock, asynchronous active-low reset
//   thread_en                   per-thread run enable
//   stall                       freezes issue, slot pointer and sequential PC advance
//   ex_branch/ex_thread_id/ex_target    taken-branch redirect from EX
//   pc_load_en/pc_load_tid/pc_load_val  software PC preload
//   if_valid/if_thread_id/if_pc registered fetch slot presented to IMEM and IF/ID
//   issue_cnt                   saturating count of valid issues
//   FIXED_SLOT                  1 = barrel slot per cycle, 0 = round-robin over enabled threads
module thread_pc_scheduler
   import thread_pc_scheduler_pkg::*;
#(
   parameter bit FIXED_SLOT = 1'b1
) (
   input  logic                   clk,
   input  logic                   sys_rstb,
   input  logic [NUM_THREADS-1:0] thread_en,
   input  logic                   stall,
   input  logic                   ex_branch,
   input  tid_t                   ex_thread_id,
   input  pc_t                    ex_target,
   input  logic                   pc_load_en,
   input  tid_t                   pc_load_tid,
   input  pc_t                    pc_load_val,
   output logic                   if_valid,
   output tid_t                   if_thread_id,
   output pc_t                    if_pc,
   output logic [31:0]            issue_cnt
);
   pc_t  pc [NUM_THREADS];
   tid_t ptr;
   tid_t gnt_idx;
   logic gnt_vld;
   tid_t sel;
   logic sel_vld;
   logic issue;

   // In round-robin mode ptr is (last issued + 1); in barrel mode it is the current slot.
   rr_pick #(.N(NUM_THREADS), .W(TID_W)) u_pick (
      .req     (thread_en),
      .start   (ptr),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   assign sel     = FIXED_SLOT ? ptr : gnt_idx;
   assign sel_vld = FIXED_SLOT ? thread_en[ptr] : gnt_vld;
   assign issue   = !stall && sel_vld;

   // Barrel mode always advances and emits a (possibly bubble) slot; round-robin with
   // nothing enabled emits a bubble and keeps pointer, thread id and PC.
   always_ff @(posedge clk or negedge sys_rstb) begin
      if (!sys_rstb) begin
         ptr          <= '0;
         if_valid     <= 1'b0;
         if_thread_id <= '0;
         if_pc        <= pc_t'(RESET_PC);
         issue_cnt    <= '0;
      end else if (!stall) begin
         if (FIXED_SLOT || gnt_vld) begin
            if_valid     <= sel_vld;
            if_thread_id <= sel;
            if_pc        <= pc[sel];
            ptr          <= next_tid(sel);
         end else begin
            if_valid <= 1'b0;
         end
         if (issue && issue_cnt != '1) issue_cnt <= issue_cnt + 32'd1;
      end
   end

   // Per-thread write port: preload beats branch beats sequential increment.
   // A branch landing on the issuing thread drops its increment.
   always_ff @(posedge clk or negedge sys_rstb) begin
      if (!sys_rstb) begin
         for (int t = 0; t < NUM_THREADS; t++) pc[t] <= pc_t'(RESET_PC);
      end else begin
         for (int t = 0; t < NUM_THREADS; t++) begin
            if (pc_load_en && pc_load_tid == tid_t'(t)) pc[t] <= pc_load_val;
            else if (ex_branch && ex_thread_id == tid_t'(t)) pc[t] <= ex_target;
            else if (issue && sel == tid_t'(t)) pc[t] <= pc[t] + pc_t'(PC_INC);
         end
      end
   end
endmodule

// File: tb/tb_thread_pc_scheduler.sv
// tb_thread_pc_scheduler: checks barrel and round-robin instances against a behavioural model.
module tb_thread_pc_scheduler;
   import thread_pc_scheduler_pkg::*;

   logic                   clk = 1'b0;
   logic                   sys_rstb = 1'b0;
   logic [NUM_THREADS-1:0] thread_en;
   logic                   stall, ex_branch, pc_load_en;
   tid_t                   ex_thread_id, pc_load_tid;
   pc_t                    ex_target, pc_load_val;
   logic                   fv, rv;
   tid_t                   ftid, rtid;
   pc_t                    fpc, rpc;
   logic [31:0]            fcnt, rcnt;

   int passed = 0;
   int total  = 0;

   // model state: barrel slot = unstalled cycles mod N; round-robin remembers last issued
   int fn, r_last;
   int mf_pc [NUM_THREADS];
   int mr_pc [NUM_THREADS];
   int ef_v, ef_tid, ef_pc, ef_cnt;
   int er_v, er_tid, er_pc, er_cnt;

   always #5 clk = ~clk;

   thread_pc_scheduler #(.FIXED_SLOT(1'b1)) u_fix (
      .clk(clk), .sys_rstb(sys_rstb), .thread_en(thread_en), .stall(stall),
      .ex_branch(ex_branch), .ex_thread_id(ex_thread_id), .ex_target(ex_target),
      .pc_load_en(pc_load_en), .pc_load_tid(pc_load_tid), .pc_load_val(pc_load_val),
      .if_valid(fv), .if_thread_id(ftid), .if_pc(fpc), .issue_cnt(fcnt)
   );

   thread_pc_scheduler #(.FIXED_SLOT(1'b0)) u_rr (
      .clk(clk), .sys_rstb(sys_rstb), .thread_en(thread_en), .stall(stall),
      .ex_branch(ex_branch), .ex_thread_id(ex_thread_id), .ex_target(ex_target),
      .pc_load_en(pc_load_en), .pc_load_tid(pc_load_tid), .pc_load_val(pc_load_val),
      .if_valid(rv), .if_thread_id(rtid), .if_pc(rpc), .issue_cnt(rcnt)
   );

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      fn = 0;
      r_last = NUM_THREADS - 1;
      for (int t = 0; t < NUM_THREADS; t++) begin
         mf_pc[t] = RESET_PC;
         mr_pc[t] = RESET_PC;
      end
      ef_v = 0; ef_tid = 0; ef_pc = RESET_PC; ef_cnt = 0;
      er_v = 0; er_tid = 0; er_pc = RESET_PC; er_cnt = 0;
   endtask

   function automatic int next_pc(int old, int t, bit inc);
      int v;
      v = inc ? (old + PC_INC) % (1 << PC_W) : old;
      if (ex_branch && int'(ex_thread_id) == t) v = int'(ex_target);
      if (pc_load_en && int'(pc_load_tid) == t) v = int'(pc_load_val);
      return v;
   endfunction

   task automatic tick();
      int  s, g;
      bit  fi, ri;
      s  = fn % NUM_THREADS;
      fi = !stall && thread_en[s];
      if (!stall) begin
         ef_v = thread_en[s]; ef_tid = s; ef_pc = mf_pc[s];
         if (fi) ef_cnt++;
         fn++;
      end
      g = -1;
      for (int k = 1; k <= NUM_THREADS; k++)
         if (g < 0 && thread_en[(r_last + k) % NUM_THREADS]) g = (r_last + k) % NUM_THREADS;
      ri = !stall && g >= 0;
      if (!stall) begin
         er_v = (g >= 0);
         if (g >= 0) begin
            er_tid = g; er_pc = mr_pc[g]; er_cnt++; r_last = g;
         end
      end
      for (int t = 0; t < NUM_THREADS; t++) begin
         mf_pc[t] = next_pc(mf_pc[t], t, fi && t == s);
         mr_pc[t] = next_pc(mr_pc[t], t, ri && t == g);
      end
      @(posedge clk);
      #1;
      chk("fix_valid", 32'(fv), ef_v);
      chk("fix_tid", 32'(ftid), ef_tid);
      if (ef_v != 0) chk("fix_pc", 32'(fpc), ef_pc);
      chk("fix_cnt", fcnt, ef_cnt);
      chk("rr_valid", 32'(rv), er_v);
      chk("rr_tid", 32'(rtid), er_tid);
      chk("rr_pc", 32'(rpc), er_pc);
      chk("rr_cnt", rcnt, er_cnt);
   endtask

   task automatic do_reset();
      sys_rstb = 1'b0;
      #1;
      chk("rst_fix_valid", 32'(fv), 0);
      chk("rst_fix_tid", 32'(ftid), 0);
      chk("rst_fix_pc", 32'(fpc), RESET_PC);
      chk("rst_fix_cnt", fcnt, 0);
      chk("rst_rr_valid", 32'(rv), 0);
      chk("rst_rr_tid", 32'(rtid), 0);
      chk("rst_rr_pc", 32'(rpc), RESET_PC);
      chk("rst_rr_cnt", rcnt, 0);
      #1;
      sys_rstb = 1'b1;
      model_reset();
   endtask

   initial begin
      thread_en = '0; stall = 1'b0; ex_branch = 1'b0; pc_load_en = 1'b0;
      ex_thread_id = '0; pc_load_tid = '0; ex_target = '0; pc_load_val = '0;
      @(posedge clk);
      #1;
      do_reset();
      // all threads enabled: strict rotation, second lap sees PC advanced by one increment
      thread_en = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("t1_tid", 32'(ftid), i % 4);
         if (i >= 4) chk("t1_pc_lap2", 32'(fpc), 4);
      end
      // sparse mask: barrel bubbles on disabled slots
      do_reset();
      thread_en = 4'b0101;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("t2_valid", 32'(fv), (i % 2 == 0) ? 1 : 0);
      end
      chk("t2_cnt", fcnt, 4);
      // round-robin skips disabled threads, then holds when none enabled
      do_reset();
      thread_en = 4'b1001;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t3_tid", 32'(rtid), (i % 2) ? 3 : 0);
      end
      thread_en = 4'b0000;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("t3_idle_valid", 32'(rv), 0);
         chk("t3_idle_tid", 32'(rtid), 3);
      end
      // branch to the thread issuing in the same cycle overrides its increment
      do_reset();
      thread_en = 4'b1111;
      pc_load_en = 1'b1; pc_load_tid = 2; pc_load_val = 9'h010;
      tick();
      pc_load_en = 1'b0;
      tick();
      ex_branch = 1'b1; ex_thread_id = 2; ex_target = 9'h040;
      tick();
      chk("t4_issue_pc", 32'(fpc), 9'h010);
      ex_branch = 1'b0;
      repeat (3) tick();
      tick();
      chk("t4_tid", 32'(ftid), 2);
      chk("t4_redirect_pc", 32'(fpc), 9'h040);
      // load beats branch on the same thread; PC wraps modulo 2^PC_W
      pc_load_en = 1'b1; pc_load_tid = 1; pc_load_val = 9'h100;
      ex_branch = 1'b1; ex_thread_id = 1; ex_target = 9'h080;
      tick();
      ex_branch = 1'b0;
      pc_load_tid = 0; pc_load_val = 9'h1FC;
      tick();
      pc_load_en = 1'b0;
      tick();
      chk("t5_load_wins", 32'(fpc), 9'h100);
      repeat (2) tick();
      tick();
      chk("t5_pre_wrap", 32'(fpc), 9'h1FC);
      repeat (3) tick();
      tick();
      chk("t5_wrap", 32'(fpc), 0);
      // stall freezes issue while a branch still writes the PC
      stall = 1'b1;
      ex_branch = 1'b1; ex_thread_id = 0; ex_target = 9'h020;
      tick();
      ex_branch = 1'b0;
      repeat (2) tick();
      stall = 1'b0;
      repeat (3) tick();
      tick();
      chk("t6_tid", 32'(ftid), 0);
      chk("t6_branch_pc", 32'(fpc), 9'h020);
      // asynchronous reset mid-run
      do_reset();
      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         thread_en    = ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
         stall        = ($urandom_range(0, 7) == 0);
         ex_branch    = ($urandom_range(0, 3) == 0);
         ex_thread_id = tid_t'($urandom_range(0, NUM_THREADS - 1));
         ex_target    = pc_t'($urandom);
         pc_load_en   = ($urandom_range(0, 5) == 0);
         pc_load_tid  = tid_t'($urandom_range(0, NUM_THREADS - 1));
         pc_load_val  = pc_t'($urandom);
         tick();
         if (i == 200) do_reset();
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
